// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state, transaction
// owner and the AddrMode encoding that fetch requests are forced to.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // AddrMode value for a full 32-bit word access (byte=0, half=1, word=2).
  localparam logic [2:0] MODE_WORD = 3'b010;

endpackage

// File: rtl/arb_pick.sv
// Winner select between the fetch and data requesters.
// Build option ARB_ROUND_ROBIN_EN: ties go to the requester that did not win
// last time; otherwise data always beats fetch because it is the older
// instruction.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   i_last_is_d,
  output owner_e o_pick
);

`ifdef ARB_ROUND_ROBIN_EN
  // Alternate on a tie, otherwise grant whoever is asking.
  always_comb begin
    // NOTE: give every combinationally assigned signal a default first so no
    // path through the block leaves it unassigned and infers a latch.
    o_pick = OWN_NONE;
    if (i_req && d_req) begin
      o_pick = i_last_is_d ? OWN_I : OWN_D;
    end else if (d_req) begin
      o_pick = OWN_D;
    end else if (i_req) begin
      o_pick = OWN_I;
    end
  end
`else
  // Fixed priority has no use for the previous winner.
  logic w_unused_last;
  assign w_unused_last = i_last_is_d;

  // Data first, then fetch.
  always_comb begin
    o_pick = OWN_NONE;
    if (d_req) begin
      o_pick = OWN_D;
    end else if (i_req) begin
      o_pick = OWN_I;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the memory stage.
// Four-state FSM: IDLE picks and latches a request, REQ holds m_req until
// m_gnt, WAIT collects m_rvalid, RESP pulses the owner's valid for one cycle.
// Build option ARB_ROUND_ROBIN_EN adds a last-owner register for fair ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  // fetch requester
  input  logic              i_req,
  input  logic [WIDTH-1:0]  i_addr,
  output logic [WIDTH-1:0]  i_rdata,
  output logic              i_valid,
  output logic              i_stall,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WIDTH-1:0]  d_addr,
  input  logic [WIDTH-1:0]  d_wdata,
  input  logic [MODE_W-1:0] d_mode,
  output logic [WIDTH-1:0]  d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  // memory port
  output logic              m_req,
  output logic              m_we,
  output logic [WIDTH-1:0]  m_addr,
  output logic [WIDTH-1:0]  m_wdata,
  output logic [MODE_W-1:0] m_mode,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [WIDTH-1:0]  m_rdata
);

  state_e             r_state;
  state_e             w_next;
  owner_e             r_owner;
  owner_e             w_pick;
  logic               w_last_is_d;
  logic               w_m_req;
  logic               r_m_we;
  logic [WIDTH-1:0]   r_m_addr;
  logic [WIDTH-1:0]   r_m_wdata;
  logic [MODE_W-1:0]  r_m_mode;
  logic [WIDTH-1:0]   r_i_rdata;
  logic [WIDTH-1:0]   r_d_rdata;
  logic               r_i_valid;
  logic               r_d_valid;

  arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .i_last_is_d (w_last_is_d),
    .o_pick      (w_pick)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_is_d;

  // Remember who won the most recent grant; starts as fetch so data wins the
  // first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_is_d <= 1'b0;
    end else if (r_state == ST_IDLE && w_pick != OWN_NONE) begin
      r_last_is_d <= (w_pick == OWN_D);
    end
  end

  assign w_last_is_d = r_last_is_d;
`else
  assign w_last_is_d = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples pre-edge values regardless of statement order.
      r_state <= w_next;
    end
  end

  // Next-state: m_rvalid is only looked at in WAIT, so strays are harmless.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_pick != OWN_NONE) w_next = ST_REQ;
      ST_REQ:  if (m_gnt)              w_next = ST_WAIT;
      ST_WAIT: if (m_rvalid)           w_next = ST_RESP;
      ST_RESP:                         w_next = ST_IDLE;
      default:                         w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: the memory request is live only in REQ.
  always_comb begin
    w_m_req = (r_state == ST_REQ);
  end

  // Latch the winner's request, capture the response and raise the owner's
  // valid so it is high exactly during RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner   <= OWN_NONE;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_mode  <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
    end else begin
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick == OWN_D) begin
            r_owner   <= OWN_D;
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
            r_m_mode  <= d_mode;
          end else if (w_pick == OWN_I) begin
            r_owner   <= OWN_I;
            r_m_we    <= 1'b0;
            r_m_addr  <= i_addr;
            r_m_mode  <= MODE_W'(MODE_WORD);
          end
        end
        ST_WAIT: begin
          if (m_rvalid) begin
            if (r_owner == OWN_I) begin
              r_i_rdata <= m_rdata;
              r_i_valid <= 1'b1;
            end else if (r_owner == OWN_D) begin
              r_d_rdata <= m_rdata;
              r_d_valid <= 1'b1;
            end
          end
        end
        ST_RESP: r_owner <= OWN_NONE;
        default: ;
      endcase
    end
  end

  assign m_req   = w_m_req;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_mode  = r_m_mode;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign i_valid = r_i_valid;
  assign d_valid = r_d_valid;
  assign i_stall = i_req & ~r_i_valid;
  assign d_stall = d_req & ~r_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Two requester agents issue
// transactions from queues, a behavioural memory answers with configurable or
// random grant/response delays, and a transaction-level model predicts the
// winner, the pass-through fields, the completion cycle and the returned data.
// Honours ARB_ROUND_ROBIN_EN for the expected tie-break policy.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int WIDTH  = 32;
  localparam int MODE_W = 3;
  localparam logic [2:0] M_BYTE = 3'b000;
  localparam logic [2:0] M_WORD = 3'b010;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  mode;
    int          dly;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [2:0]  d_mode = '0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_valid, i_stall, d_valid, d_stall, m_req, m_we;
  logic [2:0]  m_mode;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(WIDTH), .MODE_W(MODE_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mode(d_mode),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_mode(m_mode),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Initial memory contents, also the expected fetch data.
  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction

  // configuration written by the main sequence
  bit rand_dly = 1'b0;
  int cfg_gw = 0, cfg_rw = 0;
  bit stray_rv = 1'b0;

  // requester agents and model state
  txn_t i_q[$], d_q[$];
  txn_t i_cur, d_cur;
  bit i_busy, d_busy, i_done, d_done;
  int i_gap, d_gap, i_issue, d_issue, i_lat, d_lat;
  logic [31:0] d_exp;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] d_model [logic [31:0]];

  // memory-side model state
  int cyc = 0, ph = 0, cnt = 0, fl_rw = 0, exp_vcyc = -1;
  bit fl_is_d, fl_we, in_flight, mreq_exp, last_d, in_wait;
  bit win_d, exp_d, ev_i, ev_d;
  logic [31:0] fl_addr, fl_wdata;
  logic [7:0] win_log = '0;
  int mreq_cycles = 0, last_mreq_cycles = 0;

  // One process drives all stimulus #1 after the rising edge and checks
  // outputs on the falling edge.
  initial begin : agent
    forever begin
      @(posedge clk); #1;
      cyc++;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = $urandom;
      if (!rst) begin
        ph = 0; in_flight = 1'b0; mreq_exp = 1'b0; last_d = 1'b0;
        i_busy = 1'b0; d_busy = 1'b0; i_done = 1'b0; d_done = 1'b0;
        i_gap = 0; d_gap = 0; i_req = 1'b0; d_req = 1'b0;
        i_q.delete(); d_q.delete();
      end else begin
        in_wait = (ph == 2);
        if (ph == 0 && m_req) begin
          win_d = d_busy && (m_addr == d_cur.addr);
          exp_d = (i_req && d_req) ? (RR ? !last_d : 1'b1) : d_req;
          check("winner_is_d", 32'(win_d), 32'(exp_d));
          last_d = win_d;
          win_log = {win_log[6:0], win_d};
          if (win_d) begin
            check("m_addr_d", m_addr, d_cur.addr);
            check("m_we_d", 32'(m_we), 32'(d_cur.we));
            check("m_wdata_d", m_wdata, d_cur.wdata);
            check("m_mode_d", 32'(m_mode), 32'(d_cur.mode));
          end else begin
            check("m_addr_i", m_addr, i_cur.addr);
            check("m_we_i", 32'(m_we), 32'd0);
            check("m_mode_i", 32'(m_mode), 32'(M_WORD));
          end
          fl_is_d = win_d; fl_addr = m_addr; fl_we = m_we; fl_wdata = m_wdata;
          ph = 1;
          cnt   = rand_dly ? int'($urandom_range(0, 3)) : cfg_gw;
          fl_rw = rand_dly ? int'($urandom_range(0, 3)) : cfg_rw;
          mreq_cycles = 0;
        end
        mreq_exp = (ph == 1);
        if (ph == 1) begin
          if (cnt == 0) begin
            m_gnt = 1'b1;
            if (fl_we) mem[fl_addr] = fl_wdata;
            ph = 2; cnt = fl_rw;
          end else cnt--;
        end else if (ph == 2) begin
          if (cnt == 0) begin
            m_rvalid = 1'b1;
            m_rdata = fl_we ? $urandom : (mem.exists(fl_addr) ? mem[fl_addr] : mem_init(fl_addr));
            ph = 0; in_flight = 1'b1; exp_vcyc = cyc + 1;
          end else cnt--;
        end
        if (stray_rv && !in_wait) begin
          m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0;
        end
        // fetch requester: drop req on the edge that ends the valid cycle
        if (i_done) begin i_busy = 1'b0; i_done = 1'b0; i_req = 1'b0; end
        if (!i_busy && i_q.size() > 0) begin
          if (i_gap < i_q[0].dly) i_gap++;
          else begin
            i_cur = i_q.pop_front(); i_gap = 0; i_busy = 1'b1;
            i_req = 1'b1; i_addr = i_cur.addr; i_issue = cyc;
          end
        end
        // data requester
        if (d_done) begin d_busy = 1'b0; d_done = 1'b0; d_req = 1'b0; end
        if (!d_busy && d_q.size() > 0) begin
          if (d_gap < d_q[0].dly) d_gap++;
          else begin
            d_cur = d_q.pop_front(); d_gap = 0; d_busy = 1'b1;
            if (d_cur.we) d_model[d_cur.addr] = d_cur.wdata;
            else d_exp = d_model.exists(d_cur.addr) ? d_model[d_cur.addr] : mem_init(d_cur.addr);
            d_req = 1'b1; d_we = d_cur.we; d_addr = d_cur.addr;
            d_wdata = d_cur.wdata; d_mode = d_cur.mode; d_issue = cyc;
          end
        end
      end
      @(negedge clk);
      if (rst) begin
        ev_i = in_flight && (cyc == exp_vcyc) && !fl_is_d;
        ev_d = in_flight && (cyc == exp_vcyc) && fl_is_d;
        check("i_valid", 32'(i_valid), 32'(ev_i));
        check("d_valid", 32'(d_valid), 32'(ev_d));
        check("i_stall", 32'(i_stall), 32'(i_req & ~ev_i));
        check("d_stall", 32'(d_stall), 32'(d_req & ~ev_d));
        check("m_req", 32'(m_req), 32'(mreq_exp));
        if (m_req) mreq_cycles++;
        if (ev_i) begin
          check("i_rdata", i_rdata, mem_init(i_cur.addr));
          i_done = 1'b1; i_lat = cyc - i_issue; in_flight = 1'b0;
          last_mreq_cycles = mreq_cycles;
        end
        if (ev_d) begin
          if (!d_cur.we) check("d_rdata", d_rdata, d_exp);
          d_done = 1'b1; d_lat = cyc - d_issue; in_flight = 1'b0;
          last_mreq_cycles = mreq_cycles;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b0; #1;
    check("rst_m_req", 32'(m_req), 32'd0);
    check("rst_i_valid", 32'(i_valid), 32'd0);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_m_we", 32'(m_we), 32'd0);
    check("rst_m_mode", 32'(m_mode), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((i_q.size() > 0 || d_q.size() > 0 || i_busy || d_busy || ph != 0 || in_flight)
           && n < max_cyc) begin
      @(negedge clk); #1;
      n++;
    end
    check("idle_within_budget", 32'(n < max_cyc), 32'd1);
  endtask

  task automatic push_i(input logic [31:0] a, input int dly);
    txn_t t;
    t.addr = a; t.we = 1'b0; t.wdata = '0; t.mode = M_WORD; t.dly = dly;
    i_q.push_back(t);
  endtask

  task automatic push_d(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [2:0] md, input int dly);
    txn_t t;
    t.addr = a; t.we = we; t.wdata = wd; t.mode = md; t.dly = dly;
    d_q.push_back(t);
  endtask

  logic [31:0] save_i, save_d;
  int n_wait;

  initial begin : main
    do_reset();

    // single fetch, immediate grant, data one cycle later
    rand_dly = 1'b0; cfg_gw = 0; cfg_rw = 0;
    push_i(32'h100, 0);
    wait_idle(50);
    check("fetch_latency", 32'(i_lat), 32'd3);

    // byte store with a two-cycle grant delay, then read it back
    cfg_gw = 2;
    push_d(32'h2004, 1'b1, 32'h55, M_BYTE, 0);
    wait_idle(50);
    check("store_latency", 32'(d_lat), 32'd5);
    check("store_m_req_cycles", 32'(last_mreq_cycles), 32'd3);
    cfg_gw = 0;
    push_d(32'h2004, 1'b0, 32'h0, M_WORD, 0);
    wait_idle(50);

    // four simultaneous requests from each side
    do_reset();
    win_log = '0;
    for (int k = 0; k < 4; k++) begin
      push_i(32'h200 + 32'(4 * k), 0);
      push_d(32'h2010 + 32'(4 * k), 1'b0, 32'h0, M_WORD, 0);
    end
    wait_idle(200);
    check("tie_order", 32'(win_log), RR ? 32'hAA : 32'hF0);

    // stray m_rvalid while idle
    repeat (2) @(negedge clk);
    save_i = i_rdata; save_d = d_rdata;
    stray_rv = 1'b1;
    repeat (3) @(negedge clk);
    stray_rv = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_idle_i_rdata", i_rdata, save_i);
    check("stray_idle_d_rdata", d_rdata, save_d);

    // stray m_rvalid while m_req waits three cycles for its grant
    cfg_gw = 3; stray_rv = 1'b1;
    push_i(32'h140, 0);
    wait_idle(50);
    stray_rv = 1'b0; cfg_gw = 0;
    check("stray_req_latency", 32'(i_lat), 32'd6);

    // reset during WAIT, then a late m_rvalid after release
    cfg_rw = 6;
    push_i(32'h180, 0);
    n_wait = 0;
    while (ph != 2 && n_wait < 30) begin @(negedge clk); n_wait++; end
    check("reached_wait", 32'(ph), 32'd2);
    @(negedge clk);
    do_reset();
    stray_rv = 1'b1;
    repeat (3) @(negedge clk);
    stray_rv = 1'b0;
    check("post_rst_i_rdata", i_rdata, 32'd0);
    check("post_rst_m_addr", m_addr, 32'd0);
    check("post_rst_m_req", 32'(m_req), 32'd0);
    cfg_rw = 0;
    push_i(32'h1C0, 0);
    wait_idle(50);
    check("post_rst_fetch_latency", 32'(i_lat), 32'd3);

    // randomized traffic with random memory delays
    rand_dly = 1'b1;
    for (int k = 0; k < 40; k++) begin
      push_i(32'h400 + 32'(4 * $urandom_range(0, 63)), int'($urandom_range(0, 3)));
      push_d(32'h2000 + 32'(4 * $urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             $urandom, 3'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    wait_idle(5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
